// File: rtl/bpm_measure_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// bpm_measure_ctrl
//
// Sequencing controller that sits between the peak detector, the BPM
// time-interval counter and the BPM calculator. Raw peaks are filtered with
// a refractory window before being forwarded to the counter. Each captured
// interval is handed to the calculator, and the counter is then returned to
// idle with a single-cycle done pulse. Two watchdogs cover a missing closing
// beat and a calculator that never answers.
//
// Optional build macro:
//   BPM_CHAIN_EN - when defined, DONE re-enters MEASURE and re-issues the
//                  counter peak, so the closing peak of one interval opens
//                  the next one. When undefined, DONE returns to ARM.
//
// Ports:
//   i_clk            system clock
//   i_rst            synchronous active-high reset
//   i_enable         level enable; low forces IDLE
//   i_peak_in        raw single-cycle peak pulse from the detector
//   o_ctr_en         counter enable (high in every state except IDLE)
//   o_ctr_peak       counter peak_detected, single-cycle pulse
//   i_ctr_valid      counter valid
//   i_ctr_interval   counter time_counter value
//   o_ctr_done       counter BPMCalc_Done, single-cycle pulse
//   o_calc_start     single-cycle start to the BPM calculator
//   o_calc_interval  interval held from calc_start until calc_done
//   i_calc_done      calculator completion pulse
//   o_beat_valid     single-cycle pulse: measurement completed
//   o_beat_interval  last completed interval, held
//   o_no_beat        single-cycle pulse: no closing beat within TIMEOUT
//   o_err            single-cycle pulse: calculator/counter did not respond
//   o_reject_cnt     rejected or dropped peaks, saturating at 255
//   o_state          current FSM state for debug
// ---------------------------------------------------------------------------
module bpm_measure_ctrl #(
  parameter int CNT_W        = 6,
  parameter int MIN_INTERVAL = 4,
  parameter int TIMEOUT      = 60,
  parameter int CALC_TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_peak_in,
  output logic             o_ctr_en,
  output logic             o_ctr_peak,
  input  logic             i_ctr_valid,
  input  logic [CNT_W-1:0] i_ctr_interval,
  output logic             o_ctr_done,
  output logic             o_calc_start,
  output logic [CNT_W-1:0] o_calc_interval,
  input  logic             i_calc_done,
  output logic             o_beat_valid,
  output logic [CNT_W-1:0] o_beat_interval,
  output logic             o_no_beat,
  output logic             o_err,
  output logic [7:0]       o_reject_cnt,
  output logic [2:0]       o_state
);

  // One watchdog is shared between MEASURE and the calculator states, so it
  // must be wide enough for the larger of the two limits.
  localparam int WD_MAX = (TIMEOUT > CALC_TIMEOUT) ? TIMEOUT : CALC_TIMEOUT;
  localparam int WD_W   = $clog2(WD_MAX + 1);
  localparam int RF_W   = (MIN_INTERVAL < 1) ? 1 : $clog2(MIN_INTERVAL + 1);

  localparam logic [WD_W-1:0] WD_SAT     = WD_W'(WD_MAX);
  localparam logic [WD_W-1:0] WD_MEAS_TO = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_CALC_TO = WD_W'(CALC_TIMEOUT - 1);
  localparam logic [RF_W-1:0] RF_MIN     = RF_W'(MIN_INTERVAL);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARM        = 3'd1,
    ST_MEASURE    = 3'd2,
    ST_WAIT_VALID = 3'd3,
    ST_CALC       = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  state_t           r_state;
  logic [WD_W-1:0]  r_wd;
  logic [RF_W-1:0]  r_refr;
  logic [7:0]       r_reject_cnt;
  logic             r_ctr_en;
  logic             r_ctr_peak;
  logic             r_ctr_done;
  logic             r_calc_start;
  logic [CNT_W-1:0] r_calc_interval;
  logic             r_beat_valid;
  logic [CNT_W-1:0] r_beat_interval;
  logic             r_no_beat;
  logic             r_err;

  state_t           w_state_nxt;
  logic [WD_W-1:0]  w_wd_nxt;
  logic [RF_W-1:0]  w_refr_nxt;
  logic [1:0]       w_rej_inc;
  logic             w_ctr_peak_nxt;
  logic             w_ctr_done_nxt;
  logic             w_calc_start_nxt;
  logic [CNT_W-1:0] w_calc_interval_nxt;
  logic             w_beat_valid_nxt;
  logic [CNT_W-1:0] w_beat_interval_nxt;
  logic             w_no_beat_nxt;
  logic             w_err_nxt;
  logic [WD_W-1:0]  w_wd_inc;
  logic [RF_W-1:0]  w_refr_inc;
  logic [8:0]       w_rej_sum;
  logic [7:0]       w_reject_nxt;

  // Saturating increments for both timers, and the saturating reject count.
  // A zero-length interval and a dropped peak can land in the same cycle,
  // so the reject counter may advance by two.
  assign w_wd_inc     = (r_wd == WD_SAT) ? r_wd : r_wd + 1'b1;
  assign w_refr_inc   = (r_refr >= RF_MIN) ? r_refr : r_refr + 1'b1;
  assign w_rej_sum    = {1'b0, r_reject_cnt} + {7'd0, w_rej_inc};
  assign w_reject_nxt = w_rej_sum[8] ? 8'hFF : w_rej_sum[7:0];

  // Next-state and next-output logic. Every output is computed here as the
  // value it will hold after the coming edge, so all outputs are registered.
  always_comb begin
    w_state_nxt         = r_state;
    w_wd_nxt            = r_wd;
    w_refr_nxt          = r_refr;
    w_rej_inc           = 2'd0;
    w_ctr_peak_nxt      = 1'b0;
    w_ctr_done_nxt      = 1'b0;
    w_calc_start_nxt    = 1'b0;
    w_calc_interval_nxt = r_calc_interval;
    w_beat_valid_nxt    = 1'b0;
    w_beat_interval_nxt = r_beat_interval;
    w_no_beat_nxt       = 1'b0;
    w_err_nxt           = 1'b0;

    // Peaks arriving while an interval is being evaluated cannot be used.
    if (i_peak_in && (r_state == ST_WAIT_VALID || r_state == ST_CALC ||
                      r_state == ST_DONE)) begin
      w_rej_inc = 2'd1;
    end

    case (r_state)
      ST_IDLE: begin
        if (i_enable) w_state_nxt = ST_ARM;
      end

      ST_ARM: begin
        if (!i_enable) begin
          w_state_nxt = ST_IDLE;
        end else if (i_peak_in) begin
          w_state_nxt    = ST_MEASURE;
          w_ctr_peak_nxt = 1'b1;
          w_wd_nxt       = '0;
          w_refr_nxt     = '0;
        end
      end

      ST_MEASURE: begin
        if (!i_enable) begin
          w_state_nxt    = ST_IDLE;
          w_ctr_done_nxt = 1'b1;
        end else begin
          w_wd_nxt   = w_wd_inc;
          w_refr_nxt = w_refr_inc;
          // An accepted closing peak takes precedence over a timeout in
          // the same cycle.
          if (i_peak_in && (r_refr >= RF_MIN)) begin
            w_state_nxt    = ST_WAIT_VALID;
            w_ctr_peak_nxt = 1'b1;
            w_wd_nxt       = '0;
          end else begin
            if (i_peak_in) w_rej_inc = 2'd1;
            if (r_wd == WD_MEAS_TO) begin
              w_state_nxt    = ST_ARM;
              w_no_beat_nxt  = 1'b1;
              w_ctr_done_nxt = 1'b1;
            end
          end
        end
      end

      ST_WAIT_VALID: begin
        if (!i_enable) begin
          w_state_nxt    = ST_IDLE;
          w_ctr_done_nxt = 1'b1;
        end else if (i_ctr_valid) begin
          // A zero interval is meaningless to the calculator, so it is
          // counted as a reject and the counter is released.
          if (i_ctr_interval == '0) begin
            w_rej_inc      = w_rej_inc + 2'd1;
            w_ctr_done_nxt = 1'b1;
            w_state_nxt    = ST_ARM;
          end else begin
            w_calc_interval_nxt = i_ctr_interval;
            w_calc_start_nxt    = 1'b1;
            w_state_nxt         = ST_CALC;
            w_wd_nxt            = '0;
          end
        end else if (r_wd == WD_CALC_TO) begin
          w_state_nxt    = ST_ARM;
          w_err_nxt      = 1'b1;
          w_ctr_done_nxt = 1'b1;
        end else begin
          w_wd_nxt = w_wd_inc;
        end
      end

      ST_CALC: begin
        if (!i_enable) begin
          w_state_nxt    = ST_IDLE;
          w_ctr_done_nxt = 1'b1;
        end else if (i_calc_done) begin
          w_beat_interval_nxt = r_calc_interval;
          w_beat_valid_nxt    = 1'b1;
          w_ctr_done_nxt      = 1'b1;
          w_state_nxt         = ST_DONE;
        end else if (r_wd == WD_CALC_TO) begin
          w_state_nxt    = ST_ARM;
          w_err_nxt      = 1'b1;
          w_ctr_done_nxt = 1'b1;
        end else begin
          w_wd_nxt = w_wd_inc;
        end
      end

      ST_DONE: begin
        if (!i_enable) begin
          w_state_nxt = ST_IDLE;
        end else begin
`ifdef BPM_CHAIN_EN
          // The closing peak doubles as the opening peak of the next
          // interval: restart the counter straight away.
          w_state_nxt    = ST_MEASURE;
          w_ctr_peak_nxt = 1'b1;
          w_wd_nxt       = '0;
          w_refr_nxt     = '0;
`else
          w_state_nxt = ST_ARM;
`endif
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, timers and all output registers. Reset overrides everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= ST_IDLE;
      r_wd            <= '0;
      r_refr          <= '0;
      r_reject_cnt    <= '0;
      r_ctr_en        <= 1'b0;
      r_ctr_peak      <= 1'b0;
      r_ctr_done      <= 1'b0;
      r_calc_start    <= 1'b0;
      r_calc_interval <= '0;
      r_beat_valid    <= 1'b0;
      r_beat_interval <= '0;
      r_no_beat       <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_wd            <= w_wd_nxt;
      r_refr          <= w_refr_nxt;
      r_reject_cnt    <= w_reject_nxt;
      r_ctr_en        <= (w_state_nxt != ST_IDLE);
      r_ctr_peak      <= w_ctr_peak_nxt;
      r_ctr_done      <= w_ctr_done_nxt;
      r_calc_start    <= w_calc_start_nxt;
      r_calc_interval <= w_calc_interval_nxt;
      r_beat_valid    <= w_beat_valid_nxt;
      r_beat_interval <= w_beat_interval_nxt;
      r_no_beat       <= w_no_beat_nxt;
      r_err           <= w_err_nxt;
    end
  end

  assign o_ctr_en        = r_ctr_en;
  assign o_ctr_peak      = r_ctr_peak;
  assign o_ctr_done      = r_ctr_done;
  assign o_calc_start    = r_calc_start;
  assign o_calc_interval = r_calc_interval;
  assign o_beat_valid    = r_beat_valid;
  assign o_beat_interval = r_beat_interval;
  assign o_no_beat       = r_no_beat;
  assign o_err           = r_err;
  assign o_reject_cnt    = r_reject_cnt;
  assign o_state         = r_state;

endmodule
